systolic_feed_controller: RTL and testbench
===========================================

SYSTOLIC_FEED_CONTROLLER -- requirements
Module: systolic_feed_controller

Interface
REQ-001 Parameters SHALL be: N, default 32, array dimension and staging width; ADDR_W, default 16, unified-buffer and accumulator address width; OUT_LAT, default 64, cycles from first staging read to first accumulator-valid row, minimum 2.
REQ-002 Ports SHALL be:
- clk_i  input  1  single clock, all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle request to run one activation pass.
- weights_ready_i  input  1  weight tile is resident in the array.
- cfg_rows_i  input  8  row count minus one (1..256 rows).
- cfg_ub_base_i  input  ADDR_W  first unified-buffer row address.
- cfg_acc_base_i  input  ADDR_W  first accumulator row address.
- busy_o  output  1  pass in progress.
- done_o  output  1  one-cycle pass-complete pulse.
- ub_rd_en_o  output  1  unified-buffer row read enable.
- ub_rd_addr_o  output  ADDR_W  unified-buffer row address.
- stage_read_o  output  1  drives the staging block read input.
- acc_wr_en_o  output  1  accumulator row write enable.
- acc_wr_addr_o  output  ADDR_W  accumulator row address.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-004 In IDLE, start_i=1 with weights_ready_i=1 SHALL latch cfg_rows_i, cfg_ub_base_i, cfg_acc_base_i and enter FETCH next cycle; start_i with weights_ready_i=0 SHALL be dropped, not queued.
REQ-005 start_i outside IDLE SHALL be ignored; config inputs SHALL be sampled only at accepted start.
REQ-006 In FETCH, ub_rd_en_o and stage_read_o SHALL both be 1 every cycle, with ub_rd_addr_o = latched base + row index, row index 0..rows-1, no gaps.
REQ-007 stage_read_o SHALL equal ub_rd_en_o in the same cycle (unified buffer has 1-cycle read latency; staging captures data one cycle later).
REQ-008 After issuing row index rows-1, FSM SHALL enter DRAIN; ub_rd_en_o and stage_read_o SHALL be 0 outside FETCH.
REQ-009 A valid delay line of OUT_LAT stages SHALL shift each cycle, input = stage_read_o; acc_wr_en_o SHALL be its output, so acc_wr_en_o is asserted exactly rows cycles, beginning OUT_LAT cycles after the first stage_read_o.
REQ-010 acc_wr_addr_o SHALL start at latched accumulator base and increment by 1 after each cycle with acc_wr_en_o=1; address arithmetic SHALL wrap modulo 2^ADDR_W for both counters.
REQ-011 DRAIN SHALL exit to DONE in the cycle after the last acc_wr_en_o (delay line empty); DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-012 busy_o SHALL be 1 in FETCH, DRAIN, DONE; 0 in IDLE.
REQ-013 start_i during DONE SHALL be ignored; start_i in the first IDLE cycle after DONE SHALL be accepted.
REQ-014 rows=1 (cfg_rows_i=0) SHALL give one FETCH cycle; rows=256 (cfg_rows_i=255) SHALL give 256 FETCH cycles without counter overflow (9-bit row counter).

Reset
REQ-015 rst_ni low SHALL asynchronously force IDLE, clear delay line, counters and latched config; all outputs 0.
REQ-016 Reset mid-pass SHALL abort with no done_o pulse and no further acc_wr_en_o after release.
REQ-017 Reset release SHALL be synchronous to clk_i; first start_i accepted on first rising edge with rst_ni high.

Structure
REQ-018 FSM state enum and N, ADDR_W defaults SHALL reside in shared package tpu_pkg.
REQ-019 The valid delay line SHALL be one sub-module, valid_delay_line, parameterised by depth, with async active-low reset.
REQ-020 No combinational path SHALL exist from start_i to any output.

Verification
REQ-021 cfg_rows_i=3, ub base 0x0010, acc base 0x0200, start with weights ready -> ub_rd_addr_o 0x10..0x13 on 4 consecutive cycles; acc_wr_en_o 4 cycles from OUT_LAT after first read, addresses 0x200..0x203; done_o once.
REQ-022 start_i with weights_ready_i=0 -> busy_o stays 0, no reads; later start with ready=1 -> normal pass.
REQ-023 cfg_rows_i=0 and cfg_rows_i=255 -> exactly 1 and 256 reads and writes respectively.
REQ-024 ub base 0xFFFE, cfg_rows_i=3 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-025 rst_ni pulsed low mid-FETCH and mid-DRAIN -> outputs 0 immediately; no done_o or acc_wr_en_o after release.
REQ-026 start_i held high continuously -> back-to-back passes separated by exactly one IDLE cycle after DONE.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default array/address sizing and the feed-controller state encoding.
package tpu_pkg;

   localparam int unsigned N_DEF      = 32;
   localparam int unsigned ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feed_state_e;

   // cfg_rows_i encodes rows-1, so 8 bits cover 1..256; the result needs 9 bits.
   function automatic logic [8:0] rows_from_cfg(input logic [7:0] cfg_rows);
      return {1'b0, cfg_rows} + 9'd1;
   endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tracks row-valid tokens through the array pipeline.
module valid_delay_line #(
   parameter int unsigned DEPTH = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic valid_i,
   output logic valid_o,
   output logic inner_busy_o
);

   logic [DEPTH-1:0] stages_q;

   // Shift one stage per clock; reset flushes every in-flight token.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stages_q <= {DEPTH{1'b0}};
      end else begin
         stages_q <= {stages_q[DEPTH-2:0], valid_i};
      end
   end

   assign valid_o      = stages_q[DEPTH-1];
   // Any token short of the output stage means more accumulator writes are still coming.
   assign inner_busy_o = |stages_q[DEPTH-2:0];

endmodule

// File: rtl/systolic_feed_controller.sv
// Sequences one activation pass: streams unified-buffer rows into staging, then tracks the
// delayed results out to the accumulator and pulses done when the pipeline has drained.
module systolic_feed_controller
   import tpu_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned OUT_LAT = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              weights_ready_i,
   input  logic [7:0]        cfg_rows_i,
   input  logic [ADDR_W-1:0] cfg_ub_base_i,
   input  logic [ADDR_W-1:0] cfg_acc_base_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ub_rd_en_o,
   output logic [ADDR_W-1:0] ub_rd_addr_o,
   output logic              stage_read_o,
   output logic              acc_wr_en_o,
   output logic [ADDR_W-1:0] acc_wr_addr_o
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   if (N < 1 || OUT_LAT < 2) begin : g_param_check
      $error("systolic_feed_controller: N must be >= 1 and OUT_LAT >= 2");
   end

   feed_state_e       state_q;
   logic [8:0]        rows_q;
   logic [8:0]        row_idx_q;
   logic [ADDR_W-1:0] ub_addr_q;
   logic [ADDR_W-1:0] acc_addr_q;
   logic              rd_en_q;
   logic              busy_q;
   logic              done_q;

   logic              accept;
   logic              last_row;
   logic              acc_valid;
   logic              pipe_inner_busy;

   assign accept   = (state_q == ST_IDLE) && start_i && weights_ready_i;
   assign last_row = (row_idx_q + 9'd1) == rows_q;

   // Pass sequencer; every output is a flop so start_i never reaches a port combinationally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         rows_q     <= 9'd0;
         row_idx_q  <= 9'd0;
         ub_addr_q  <= {ADDR_W{1'b0}};
         acc_addr_q <= {ADDR_W{1'b0}};
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q   <= ST_FETCH;
                  rows_q    <= rows_from_cfg(cfg_rows_i);
                  row_idx_q <= 9'd0;
                  ub_addr_q <= cfg_ub_base_i;
                  rd_en_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (last_row) begin
                  state_q <= ST_DRAIN;
                  rd_en_q <= 1'b0;
               end else begin
                  row_idx_q <= row_idx_q + 9'd1;
                  ub_addr_q <= ub_addr_q + ADDR_ONE;
               end
            end
            ST_DRAIN: begin
               // Final token is at the output with nothing behind it: next cycle is DONE.
               if (acc_valid && !pipe_inner_busy) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               rd_en_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase

         if (accept) begin
            acc_addr_q <= cfg_acc_base_i;
         end else if (acc_valid) begin
            acc_addr_q <= acc_addr_q + ADDR_ONE;
         end else begin
            acc_addr_q <= acc_addr_q;
         end
      end
   end

   valid_delay_line #(
      .DEPTH (OUT_LAT)
   ) u_valid_delay_line (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .valid_i      (rd_en_q),
      .valid_o      (acc_valid),
      .inner_busy_o (pipe_inner_busy)
   );

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign ub_rd_en_o    = rd_en_q;
   assign stage_read_o  = rd_en_q;
   assign ub_rd_addr_o  = ub_addr_q;
   assign acc_wr_en_o   = acc_valid;
   assign acc_wr_addr_o = acc_addr_q;

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Scoreboard bench: stimulus pushes expected (cycle, address) events; a negedge monitor pops and compares.
module tb_systolic_feed_controller;

   localparam int LAT = 64;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        wready = 1'b0;
   logic [7:0]  cfg_rows = 8'd0;
   logic [15:0] cfg_ub = 16'd0;
   logic [15:0] cfg_acc = 16'd0;
   logic        busy, done, rd_en, stage_rd, wr_en;
   logic [15:0] rd_addr, wr_addr;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   ev_t rdq[$];
   ev_t wrq[$];
   int  doneq[$];

   systolic_feed_controller #(
      .N       (32),
      .ADDR_W  (16),
      .OUT_LAT (LAT)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .weights_ready_i (wready),
      .cfg_rows_i      (cfg_rows),
      .cfg_ub_base_i   (cfg_ub),
      .cfg_acc_base_i  (cfg_acc),
      .busy_o          (busy),
      .done_o          (done),
      .ub_rd_en_o      (rd_en),
      .ub_rd_addr_o    (rd_addr),
      .stage_read_o    (stage_rd),
      .acc_wr_en_o     (wr_en),
      .acc_wr_addr_o   (wr_addr)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_pass(input int k, input int rows, input logic [15:0] ub, input logic [15:0] acc);
      for (int i = 0; i < rows; i++) begin
         rdq.push_back('{k + i, ub + 16'(i)});
         wrq.push_back('{k + LAT + i, acc + 16'(i)});
      end
      doneq.push_back(k + LAT + rows);
   endtask

   // Monitor: pops and compares every DUT-presented event.
   initial begin
      ev_t e;
      int  d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("stage_read_eq_rd_en", {63'd0, stage_rd}, {63'd0, rd_en});
            while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
               e = rdq.pop_front();
               check("missed_ub_read", 64'(cyc), 64'(e.cyc));
            end
            while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
               e = wrq.pop_front();
               check("missed_acc_write", 64'(cyc), 64'(e.cyc));
            end
            while (doneq.size() > 0 && doneq[0] < cyc) begin
               d = doneq.pop_front();
               check("missed_done", 64'(cyc), 64'(d));
            end
            if (rd_en) begin
               if (rdq.size() == 0) begin
                  check("unexpected_ub_read", 64'd1, 64'd0);
               end else begin
                  e = rdq.pop_front();
                  check("ub_read_cycle", 64'(cyc), 64'(e.cyc));
                  check("ub_rd_addr", 64'(rd_addr), 64'(e.addr));
               end
            end
            if (wr_en) begin
               if (wrq.size() == 0) begin
                  check("unexpected_acc_write", 64'd1, 64'd0);
               end else begin
                  e = wrq.pop_front();
                  check("acc_write_cycle", 64'(cyc), 64'(e.cyc));
                  check("acc_wr_addr", 64'(wr_addr), 64'(e.addr));
               end
            end
            if (done) begin
               if (doneq.size() == 0) begin
                  check("unexpected_done", 64'd1, 64'd0);
               end else begin
                  d = doneq.pop_front();
                  check("done_cycle", 64'(cyc), 64'(d));
               end
            end
         end
      end
   end

   task automatic check_outputs_zero(input string name);
      check(name, {15'd0, busy, done, rd_en, stage_rd, wr_en, rd_addr, wr_addr}, 64'd0);
   endtask

   // Issue a one-cycle start at a negedge; the accepting edge is the next posedge.
   task automatic start_pass(input logic [7:0] rm1, input logic [15:0] ub, input logic [15:0] acc,
                             input logic rdy, input logic expect_accept);
      @(negedge clk);
      cfg_rows = rm1;
      cfg_ub   = ub;
      cfg_acc  = acc;
      wready   = rdy;
      start    = 1'b1;
      if (expect_accept) push_pass(cyc + 1, int'(rm1) + 1, ub, acc);
      @(negedge clk);
      start    = 1'b0;
      cfg_rows = 8'hA5;
      cfg_ub   = 16'hDEAD;
      cfg_acc  = 16'hBEEF;
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rdq.size() == 0 && wrq.size() == 0 && doneq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_idle_timeout", {63'd0, ok}, 64'd1);
   endtask

   task automatic reset_pulse(input string name);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero(name);
      rdq.delete();
      wrq.delete();
      doneq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k1;
      int k2;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 4-row pass, with busy observed mid-pass.
      start_pass(8'd3, 16'h0010, 16'h0200, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("busy_mid_pass", {63'd0, busy}, 64'd1);
      wait_idle(400);

      // Start without resident weights is dropped, then a normal pass.
      start_pass(8'd2, 16'h0040, 16'h0300, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("busy_after_dropped_start", {63'd0, busy}, 64'd0);
      start_pass(8'd2, 16'h0040, 16'h0300, 1'b1, 1'b1);
      wait_idle(400);

      // Row-count boundaries; a stray start mid-pass must be ignored.
      start_pass(8'd0, 16'h0100, 16'h0010, 1'b1, 1'b1);
      wait_idle(400);
      start_pass(8'd255, 16'h1000, 16'h2000, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      start_pass(8'd7, 16'h7777, 16'h8888, 1'b1, 1'b0);
      wait_idle(1000);

      // Both address counters wrap.
      start_pass(8'd3, 16'hFFFE, 16'hFFFF, 1'b1, 1'b1);
      wait_idle(400);

      // start held high: second pass accepted after exactly one IDLE cycle following DONE.
      @(negedge clk);
      cfg_rows = 8'd1;
      cfg_ub   = 16'h0500;
      cfg_acc  = 16'h0600;
      wready   = 1'b1;
      start    = 1'b1;
      k1 = cyc + 1;
      k2 = k1 + LAT + 2 + 2;
      push_pass(k1, 2, 16'h0500, 16'h0600);
      push_pass(k2, 2, 16'h0500, 16'h0600);
      for (int i = 0; i < 400 && cyc < k2; i++) @(negedge clk);
      start = 1'b0;
      wait_idle(400);

      // Reset mid-FETCH and mid-DRAIN: outputs clear immediately, nothing follows release.
      start_pass(8'd255, 16'h3000, 16'h4000, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      reset_pulse("reset_mid_fetch_outputs");
      repeat (100) @(negedge clk);
      check("busy_after_fetch_abort", {63'd0, busy}, 64'd0);
      start_pass(8'd3, 16'h3100, 16'h4100, 1'b1, 1'b1);
      repeat (30) @(negedge clk);
      reset_pulse("reset_mid_drain_outputs");
      repeat (100) @(negedge clk);
      check("busy_after_drain_abort", {63'd0, busy}, 64'd0);

      // Recovery pass.
      start_pass(8'd1, 16'h0ABC, 16'h0DEF, 1'b1, 1'b1);
      wait_idle(400);

      repeat (5) @(negedge clk);
      check("rdq_empty", 64'(rdq.size()), 64'd0);
      check("wrq_empty", 64'(wrq.size()), 64'd0);
      check("doneq_empty", 64'(doneq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
